// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg : shared state encoding and elaboration helpers for mux_nto1_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buf_2.sv
// ---------------------------------------------------------------------------
// skid_buf_2 : two-entry skid buffer with registered ready (main + skid reg)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skid_buf_2
   import mux_pkg::*;
#(
   parameter int DW = 33
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   output logic          o_ready,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   input  logic          i_ready
);

   state_t        r_state;
   state_t        w_next;
   logic [DW-1:0] r_main;
   logic [DW-1:0] r_skid;
   logic          r_ready;
   logic          w_accept;
   logic          w_emit;

   assign o_ready  = r_ready & ~rst_i;
   assign o_valid  = (r_state != ST_EMPTY);
   assign o_data   = r_main;
   assign w_accept = i_valid & o_ready;
   assign w_emit   = o_valid & i_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_next = ST_ONE;
         ST_ONE: begin
            if (w_accept && !w_emit)      w_next = ST_TWO;
            else if (!w_accept && w_emit) w_next = ST_EMPTY;
         end
         ST_TWO:   if (w_emit) w_next = ST_ONE;
         default:  w_next = ST_EMPTY;
      endcase
   end

   // Ready is registered from the next state so no combinational path runs from i_ready.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_EMPTY;
         r_ready <= 1'b1;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next != ST_TWO);
         case (r_state)
            ST_EMPTY: if (w_accept) r_main <= i_data;
            ST_ONE: begin
               if (w_accept && w_emit) r_main <= i_data;
               else if (w_accept)      r_skid <= i_data;
            end
            ST_TWO:   if (w_emit) r_main <= r_skid;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_nto1_pipe.sv
// ---------------------------------------------------------------------------
// mux_nto1_pipe : N-to-1 mux with zero-fill on bad select, skid-buffered output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_nto1_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]   select_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic [WIDTH-1:0]   data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               sel_err_o,
   input  logic               err_clr_i,
   output logic [CNT_W-1:0]   err_cnt_o
);

   generate
      if (N < 2 || SEL_W < clog2(N)) begin : g_bad_params
         $error("mux_nto1_pipe: N must be >= 2 and SEL_W >= clog2(N)");
      end
   endgenerate

   logic [WIDTH-1:0] w_word;
   logic             w_sel_err;
   logic [WIDTH:0]   w_out;
   logic [CNT_W-1:0] r_err_cnt;

   always_comb begin
      w_word = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(select_i) == k) w_word = data_i[k*WIDTH +: WIDTH];
      end
   end

   generate
      if (N == (1 << SEL_W)) begin : g_full_range
         assign w_sel_err = 1'b0;
      end else begin : g_partial_range
         assign w_sel_err = (int'(select_i) >= N);
      end
   endgenerate

   skid_buf_2 #(
      .DW (WIDTH + 1)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_data  ({w_sel_err, w_word}),
      .i_valid (valid_i),
      .o_ready (ready_o),
      .o_data  (w_out),
      .o_valid (valid_o),
      .i_ready (ready_i)
   );

   assign data_o    = w_out[WIDTH-1:0];
   assign sel_err_o = w_out[WIDTH];

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || err_clr_i)
         r_err_cnt <= '0;
      else if (valid_i && ready_o && w_sel_err && (r_err_cnt != '1))
         r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign err_cnt_o = r_err_cnt;

endmodule

`default_nettype wire
